// File: rtl/operand_skew_feeder_if.sv
// Bundle of the operand feeder's load/enable inputs and its skewed edge outputs.
//   master : array controller / operand buffers side (drives load, tiles, valid_en)
//   slave  : feeder side (drives row/column operands, valids, armed, feed_done)
// Packing: A[i][k] at a_mat_i[(i*K+k)*DW +: DW], B[k][j] at b_mat_i[(k*N+j)*DW +: DW],
//          row i at a_row_o[i*DW +: DW], column j at b_col_o[j*DW +: DW].
interface operand_skew_feeder_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned DW = 8
);
  logic                load;
  logic [N*K*DW-1:0]   a_mat_i;
  logic [K*N*DW-1:0]   b_mat_i;
  logic                valid_en;
  logic [N*DW-1:0]     a_row_o;
  logic [N*DW-1:0]     b_col_o;
  logic [N-1:0]        a_vld_o;
  logic [N-1:0]        b_vld_o;
  logic                armed;
  logic                feed_done;

  modport master (
    output load, a_mat_i, b_mat_i, valid_en,
    input  a_row_o, b_col_o, a_vld_o, b_vld_o, armed, feed_done
  );

  modport slave (
    input  load, a_mat_i, b_mat_i, valid_en,
    output a_row_o, b_col_o, a_vld_o, b_vld_o, armed, feed_done
  );
endinterface

// File: rtl/operand_skew_feeder.sv
// Diagonal-skew operand feeder for an N x N systolic array.
// Latches one A (N x K) and one B (K x N) tile on `load`, then issues K+N-1
// feed steps; at step t row i carries A[i][t-i] and column j carries B[t-j][j]
// whenever that inner index lies in [0, K), otherwise zero with valid low.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - operand_skew_feeder_if.slave (load, tiles, valid_en, skewed outputs,
//          armed, feed_done); all outputs are registered.
// Build option: define OPERAND_SKEW_FEEDER_STALL_EN to let valid_en low stall
// an in-progress feed; without it valid_en only starts the feed.
module operand_skew_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned DW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_skew_feeder_if.slave  bus
);

  localparam int unsigned TW   = $clog2(K + N);
  localparam int unsigned LAST = K + N - 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FEED,
    DRAINED
  } state_t;

  state_t              state;
  logic [TW-1:0]       t;
  logic [N*K*DW-1:0]   a_lat;
  logic [K*N*DW-1:0]   b_lat;

  logic                feed_go;
  logic                issue;
  logic [N*DW-1:0]     a_row_n;
  logic [N*DW-1:0]     b_col_n;
  logic [N-1:0]        a_vld_n;
  logic [N-1:0]        b_vld_n;

`ifdef OPERAND_SKEW_FEEDER_STALL_EN
  assign feed_go = bus.valid_en;
`else
  assign feed_go = 1'b1;
`endif

  // Next-cycle edge operands. The skew is expressed as a search over (lane, k)
  // pairs with lane + k == t, which bounds the inner index without any
  // subtraction that could wrap.
  always_comb begin
    a_row_n = '0;
    b_col_n = '0;
    a_vld_n = '0;
    b_vld_n = '0;
    unique case (state)
      ARMED:   issue = bus.valid_en;
      FEED:    issue = feed_go;
      default: issue = 1'b0;
    endcase
    if (issue) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned k = 0; k < K; k++) begin
          if (32'(t) == i + k) begin
            a_row_n[i*DW +: DW] = a_lat[(i*K+k)*DW +: DW];
            a_vld_n[i]          = 1'b1;
            b_col_n[i*DW +: DW] = b_lat[(k*N+i)*DW +: DW];
            b_vld_n[i]          = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      t             <= '0;
      a_lat         <= '0;
      b_lat         <= '0;
      bus.a_row_o   <= '0;
      bus.b_col_o   <= '0;
      bus.a_vld_o   <= '0;
      bus.b_vld_o   <= '0;
      bus.armed     <= 1'b0;
      bus.feed_done <= 1'b0;
    end else begin
      bus.a_row_o <= a_row_n;
      bus.b_col_o <= b_col_n;
      bus.a_vld_o <= a_vld_n;
      bus.b_vld_o <= b_vld_n;
      unique case (state)
        IDLE, DRAINED: begin
          if (bus.load) begin
            a_lat         <= bus.a_mat_i;
            b_lat         <= bus.b_mat_i;
            t             <= '0;
            bus.feed_done <= 1'b0;
            bus.armed     <= 1'b1;
            state         <= ARMED;
          end
        end
        ARMED, FEED: begin
          // ARMED issues step 0 with t already cleared, so both states share
          // the advance path.
          if (issue) begin
            if (32'(t) == LAST) begin
              state         <= DRAINED;
              bus.armed     <= 1'b0;
              bus.feed_done <= 1'b1;
            end else begin
              state <= FEED;
              t     <= t + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
module tb_operand_skew_feeder;
  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 8;
`ifdef OPERAND_SKEW_FEEDER_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_skew_feeder_if #(.N(N), .K(K), .DW(DW)) bus ();

  operand_skew_feeder #(.N(N), .K(K), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  // A tile is "held" from accepted load until its last step; steps are numbered
  // from 0 and the outputs after an edge show whichever step (if any) that edge issued.
  int  ma [N][K];
  int  mb [K][N];
  bit  m_have = 0, m_started = 0, m_done = 0;
  int  m_next = 0;
  logic [N*DW-1:0] exp_a_row = '0, exp_b_col = '0;
  logic [N-1:0]    exp_a_vld = '0, exp_b_vld = '0;

  always @(posedge clk) begin
    int s;
    bit go;
    s = -1;
    if (rst) begin
      m_have = 0; m_started = 0; m_done = 0; m_next = 0;
    end else if (!m_have) begin
      if (bus.load) begin
        for (int i = 0; i < N; i++)
          for (int k = 0; k < K; k++) begin
            ma[i][k] = int'(bus.a_mat_i[(i*K+k)*DW +: DW]);
            mb[k][i] = int'(bus.b_mat_i[(k*N+i)*DW +: DW]);
          end
        m_have = 1; m_started = 0; m_next = 0; m_done = 0;
      end
    end else begin
      go = m_started ? (STALL ? bus.valid_en : 1'b1) : bus.valid_en;
      if (go) begin
        s = m_next;
        m_started = 1;
        m_next++;
        if (m_next == K + N - 1) begin
          m_have = 0;
          m_done = 1;
        end
      end
    end
    exp_a_row = '0; exp_b_col = '0; exp_a_vld = '0; exp_b_vld = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = s - i;
      if (s >= 0 && d >= 0 && d < K) begin
        exp_a_row[i*DW +: DW] = DW'(ma[i][d]);
        exp_b_col[i*DW +: DW] = DW'(mb[d][i]);
        exp_a_vld[i] = 1'b1;
        exp_b_vld[i] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Single compare process: every cycle against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_row", 64'(bus.a_row_o), 64'(exp_a_row));
      chk("b_col", 64'(bus.b_col_o), 64'(exp_b_col));
      chk("a_vld", 64'(bus.a_vld_o), 64'(exp_a_vld));
      chk("b_vld", 64'(bus.b_vld_o), 64'(exp_b_vld));
      chk("armed", 64'(bus.armed), 64'(m_have));
      chk("feed_done", 64'(bus.feed_done), 64'(m_done));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tiles(input int abase, input int bbase);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        bus.a_mat_i[(i*K+k)*DW +: DW] = DW'(abase + 16*i + k);
        bus.b_mat_i[(k*N+i)*DW +: DW] = DW'(bbase + 16*k + i);
      end
  endtask

  function automatic logic [63:0] lane(input logic [N*DW-1:0] v, input int i);
    return 64'(v[i*DW +: DW]);
  endfunction

  initial begin
    bus.load = 0; bus.valid_en = 0; bus.a_mat_i = '0; bus.b_mat_i = '0;
    tick(2);
    chk_on = 1;
    chk("rst_armed", 64'(bus.armed), 64'd0);
    chk("rst_done", 64'(bus.feed_done), 64'd0);
    chk("rst_a_row", 64'(bus.a_row_o), 64'd0);
    rst = 0;
    tick();

    // Basic feed
    set_tiles(0, 0);
    bus.load = 1; tick(); bus.load = 0;
    bus.valid_en = 1;
    tick();                                 // cycle 1
    chk("c1_a_vld", 64'(bus.a_vld_o), 64'b0001);
    chk("c1_a_row0", lane(bus.a_row_o, 0), 64'h00);
    tick(2);                                // cycle 3
    chk("c3_b_vld2", 64'(bus.b_vld_o[2]), 64'd1);
    chk("c3_b_col2", lane(bus.b_col_o, 2), 64'h02);
    tick();                                 // cycle 4
    chk("c4_a_vld", 64'(bus.a_vld_o), 64'b1111);
    chk("c4_a_row3", lane(bus.a_row_o, 3), 64'h30);
    chk("c4_a_row0", lane(bus.a_row_o, 0), 64'h03);
    tick(2);                                // cycle 6
    chk("c6_b_col2", lane(bus.b_col_o, 2), 64'h32);
    tick();                                 // cycle 7
    chk("c7_a_vld", 64'(bus.a_vld_o), 64'b1000);
    chk("c7_a_row3", lane(bus.a_row_o, 3), 64'h33);
    chk("c7_done", 64'(bus.feed_done), 64'd1);
    chk("c7_b_vld2", 64'(bus.b_vld_o[2]), 64'd0);
    bus.valid_en = 0;
    tick(2);

    // Two-cycle valid_en drop after step 2
    bus.load = 1; tick(); bus.load = 0;
    bus.valid_en = 1; tick(3);
    bus.valid_en = 0; tick();               // cycle 4
`ifdef OPERAND_SKEW_FEEDER_STALL_EN
    chk("st4_a_vld", 64'(bus.a_vld_o), 64'd0);
`else
    chk("st4_a_vld", 64'(bus.a_vld_o), 64'b1111);
`endif
    tick(); bus.valid_en = 1;
    tick();                                 // cycle 6
`ifdef OPERAND_SKEW_FEEDER_STALL_EN
    chk("st6_a_row1", lane(bus.a_row_o, 1), 64'h12);
`else
    chk("st6_a_row1", 64'(bus.a_vld_o[1]), 64'd0);
`endif
    tick();                                 // cycle 7
    chk("st7_done", 64'(bus.feed_done), STALL ? 64'd0 : 64'd1);
    tick(2);                                // cycle 9
    chk("st9_done", 64'(bus.feed_done), 64'd1);
    bus.valid_en = 0; tick();

    // Load during FEED is ignored
    bus.load = 1; tick(); bus.load = 0;
    bus.valid_en = 1; tick(2);
    for (int i = 0; i < N*K; i++) bus.a_mat_i[i*DW +: DW] = 8'hFF;
    bus.load = 1; tick(); bus.load = 0;     // cycle 3
    tick();                                 // cycle 4
    chk("ld_a_row0", lane(bus.a_row_o, 0), 64'h03);
    chk("ld_armed", 64'(bus.armed), 64'd1);
    tick(4);
    bus.valid_en = 0;

    // Load in DRAINED coinciding with valid_en: arms only, then new tile streams
    set_tiles(8'h80, 8'h40);
    bus.load = 1; bus.valid_en = 1; tick(); bus.load = 0;
    chk("dr_done", 64'(bus.feed_done), 64'd0);
    chk("dr_a_vld", 64'(bus.a_vld_o), 64'd0);
    tick();                                 // cycle 1
    chk("dr_a_row0", lane(bus.a_row_o, 0), 64'h80);
    chk("dr_b_col0", lane(bus.b_col_o, 0), 64'h40);
    tick(7);
    bus.valid_en = 0; tick();

    // Reset at step 3, load while in reset ignored
    set_tiles(0, 0);
    bus.load = 1; tick(); bus.load = 0;
    bus.valid_en = 1; tick(3);
    rst = 1; bus.load = 1; tick();
    chk("rs_a_vld", 64'(bus.a_vld_o), 64'd0);
    chk("rs_armed", 64'(bus.armed), 64'd0);
    chk("rs_a_row", 64'(bus.a_row_o), 64'd0);
    rst = 0; bus.load = 0; tick(4);
    chk("rs_novld", 64'(bus.a_vld_o), 64'd0);
    bus.valid_en = 0; tick();

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/operand_skew_feeder.md
# operand_skew_feeder

Diagonal-skew operand feeder between the operand buffers and the N×N systolic array, driven by the array controller's `valid_en`. It latches one A (N×K) and one B (K×N) tile, then, while `valid_en` is high, presents the left-edge row inputs and top-edge column inputs with row/column `i` delayed by `i` cycles. This creates the standard systolic wavefront. The controller's compute window of K+2N−1 cycles covers this feeder's K+N−1 feed cycles plus array drain.

## Interface
- `N`, 4, array dimension (rows of A, columns of B).
- `K`, 4, inner dimension.
- `DW`, 8, operand element width in bits.

- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle pulse; capture `a_mat_i` and `b_mat_i`.
- `a_mat_i`  in  N*K*DW  A[i][k] at bits [(i*K+k)*DW +: DW].
- `b_mat_i`  in  K*N*DW  B[k][j] at bits [(k*N+j)*DW +: DW].
- `valid_en`  in  1  advance enable from the array controller.
- `a_row_o`  out  N*DW  left-edge operand for row i at [i*DW +: DW].
- `b_col_o`  out  N*DW  top-edge operand for column j at [j*DW +: DW].
- `a_vld_o`  out  N  per-row operand valid.
- `b_vld_o`  out  N  per-column operand valid.
- `armed`  out  1  a tile is latched and not yet fully fed.
- `feed_done`  out  1  level; all K+N−1 feed steps issued, held until next accepted `load`.

## Operation
- States:
  - IDLE: after reset.
  - ARMED: tile latched, step counter `t`=0.
  - FEED: stepping.
  - DRAINED: complete.
- Transitions:
  - IDLE/DRAINED + `load` → ARMED. Latches both tiles, clears `t` and `feed_done`.
  - ARMED + `valid_en` → FEED. This cycle is step t=0.
  - FEED: each cycle with `valid_en` high issues step t, then t←t+1.
  - FEED: after issuing step t=K+N−2 → DRAINED, and `feed_done`←1.
- `load` in ARMED or FEED is ignored. The latched tile is not overwritten.
- `load` in IDLE or DRAINED coinciding with `valid_en` takes ARMED only. No step is issued that cycle.
- Step t for row i:
  - When 0 ≤ t−i < K: `a_row_o[i]`=A[i][t−i] and `a_vld_o[i]`=1.
  - Otherwise: `a_row_o[i]`=0 and `a_vld_o[i]`=0.
- Column j follows the same rule with B[t−j][j] on `b_col_o[j]` and `b_vld_o[j]`.
- Cycles that issue no step (IDLE, ARMED, DRAINED, stalled FEED) drive all data outputs and valids to 0.
- `t` is $clog2(K+N) bits wide and never exceeds K+N−1. Index arithmetic (t−i) is evaluated signed or with a range check; it must not wrap.
- `armed` = 1 in ARMED and FEED.

## Timing
- All outputs are registered. Step t issued at edge e appears on the outputs after edge e, for one cycle.
- First valid element: A[0][0] and B[0][0] appear 1 cycle after the first `valid_en`-high cycle in ARMED.
- Last valid element: A[N−1][K−1] and B[K−1][N−1] appear K+N−1 cycles after the first step.
- `feed_done` rises together with the outputs of the last step.
- Reset values: all data outputs 0, `a_vld_o`/`b_vld_o` 0, `armed` 0, `feed_done` 0, state IDLE, `t` 0.
- Reset asserted mid-FEED forces IDLE on the next edge, discards the tile, and zeros the outputs. `load` is ignored while `rst` is high.

## Configuration
- `OPERAND_SKEW_FEEDER_STALL_EN`:
  - Defined: `valid_en` low in FEED stalls. `t` holds, the cycle outputs zeros with valids low, and stepping resumes at the same t when `valid_en` returns.
  - Undefined: once in FEED, `t` advances every cycle regardless of `valid_en` until DRAINED. `valid_en` only gates the ARMED→FEED start.

## Test plan
- Basic feed: N=K=4, A[i][k]=16i+k, B[k][j]=16k+j, load then `valid_en` high.
  - Cycle 1 after start: a_vld=0001, a_row[0]=0x00.
  - Cycle 4: a_vld=1111, a_row[3]=0x30, a_row[0]=0x03.
  - Cycle 7: only row 3 valid, value 0x33; `feed_done`=1.
- Column skew, same stimulus: b_col[2] first valid at cycle 3 = 0x02 (B[0][2]) and last valid at cycle 6 = 0x32.
- Stall (macro defined): drop `valid_en` for 2 cycles after step 2.
  - Those 2 output cycles are all-zero with valids 0.
  - Step 3 resumes with a_row[1]=0x12; `feed_done` arrives 2 cycles late.
- Same stall with the macro undefined: outputs identical to the basic feed; `feed_done` at cycle 7.
- `load` during FEED with a new A of all 0xFF: ignored, the original values continue.
- `load` in DRAINED clears `feed_done`; a second run streams the new tile.
- Reset at step 3: next cycle all outputs 0, `armed`=0; a subsequent `valid_en` without `load` produces no valids.
